// File: rtl/cnt5_pkg.sv
// cnt5_pkg: shared types and constants for the 5-state counter direction decoder.
//   state_e      : decoder FSM states (ACQUIRE, TRACK, ERROR)
//   step_class_e : classification of one count transition (HOLD, UP, DN, ILLEGAL)
//   CNT5_MOD     : modulus of the observed counter
//   CNT_W        : width of the observed count bus
package cnt5_pkg;

  localparam int unsigned CNT5_MOD = 5;
  localparam int unsigned CNT_W    = 3;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    ERROR   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    UP      = 2'd1,
    DN      = 2'd2,
    ILLEGAL = 2'd3
  } step_class_e;

endpackage

// File: rtl/cnt5_step_classify.sv
// cnt5_step_classify: combinational classification of a count transition.
// Ports:
//   prev       in  CNT_W  previously accepted (in-range) count
//   cur        in  CNT_W  newly sampled count
//   step_class out        HOLD / UP / DN / ILLEGAL, with wrap at MOD-1 <-> 0
// The modulus parameter sets the legal code range; codes at or above it are always ILLEGAL.
module cnt5_step_classify
  import cnt5_pkg::*;
#(
  parameter int unsigned MOD = CNT5_MOD
) (
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] cur,
  output step_class_e      step_class
);

  localparam logic [CNT_W-1:0] MAX_CODE = CNT_W'(MOD - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO     = CNT_W'(0);

  logic [CNT_W-1:0] up_code_s;
  logic [CNT_W-1:0] dn_code_s;

  // Expected neighbours of prev (modular), then classify cur against them.
  always_comb begin
    up_code_s  = (prev == MAX_CODE) ? ZERO : (prev + ONE);
    dn_code_s  = (prev == ZERO) ? MAX_CODE : (prev - ONE);
    step_class = ILLEGAL;
    if (cur > MAX_CODE) begin
      step_class = ILLEGAL;
    end else if (cur == prev) begin
      step_class = HOLD;
    end else if (cur == up_code_s) begin
      step_class = UP;
    end else if (cur == dn_code_s) begin
      step_class = DN;
    end else begin
      step_class = ILLEGAL;
    end
  end

endmodule

// File: rtl/cnt5_dir_decoder.sv
// cnt5_dir_decoder: observer for a modulo-MOD up/down counter bus. Recovers step
// pulses and direction, keeps a signed position accumulator and flags sequence errors.
// Every output is registered: the response to a sample appears one clk later.
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high reset
//   cnt_in   in   CNT_W  observed count
//   step_up  out  1      pulse on a legal +1 step (incl. MOD-1 -> 0)
//   step_dn  out  1      pulse on a legal -1 step (incl. 0 -> MOD-1)
//   dir      out  1      last legal step direction (1 = up)
//   locked   out  1      LOCK_CNT consecutive legal steps since last acquire
//   err      out  1      illegal transition or out-of-range code
//   pos      out  POS_W  signed step count, wraps in two's complement
// Configuration macro:
//   CNT5_DEC_STICKY_ERR_EN  defined: ERROR is terminal until reset, err held high.
//                           undefined: err pulses once, then the decoder re-acquires.
module cnt5_dir_decoder
  import cnt5_pkg::*;
#(
  parameter int unsigned MOD      = CNT5_MOD,
  parameter int unsigned POS_W    = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic        [CNT_W-1:0] cnt_in,
  output logic                    step_up,
  output logic                    step_dn,
  output logic                    dir,
  output logic                    locked,
  output logic                    err,
  output logic signed [POS_W-1:0] pos
);

  localparam int unsigned      LC_W     = $clog2(LOCK_CNT + 1);
  localparam logic [LC_W-1:0]  LOCK_MAX = LC_W'(LOCK_CNT);
  localparam logic [LC_W-1:0]  LC_ONE   = LC_W'(1);
  localparam logic [LC_W-1:0]  LC_ZERO  = LC_W'(0);
  localparam logic [CNT_W-1:0] MAX_CODE = CNT_W'(MOD - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   prev_q,     prev_d;
  logic [LC_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic               step_up_q,  step_up_d;
  logic               step_dn_q,  step_dn_d;
  logic               dir_q,      dir_d;
  logic               locked_q,   locked_d;
  logic               err_q,      err_d;
  logic [POS_W-1:0]   pos_q,      pos_d;

  logic               in_range_s;
  step_class_e        step_class_s;

  cnt5_step_classify #(
    .MOD (MOD)
  ) u_classify (
    .prev       (prev_q),
    .cur        (cnt_in),
    .step_class (step_class_s)
  );

  assign in_range_s = (cnt_in <= MAX_CODE);

  // Next-state, step pulses, lock counter and position update.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    lock_cnt_d = lock_cnt_q;
    step_up_d  = 1'b0;
    step_dn_d  = 1'b0;
    dir_d      = dir_q;
    err_d      = 1'b0;
    pos_d      = pos_q;

    case (state_q)
      ACQUIRE: begin
        lock_cnt_d = LC_ZERO;
        if (in_range_s) begin
          prev_d  = cnt_in;
          state_d = TRACK;
        end else begin
          err_d = 1'b1;
        end
      end

      TRACK: begin
        // An out-of-range code never becomes the reference for later samples.
        if (in_range_s) begin
          prev_d = cnt_in;
        end else begin
          prev_d = prev_q;
        end
        case (step_class_s)
          UP: begin
            step_up_d  = 1'b1;
            dir_d      = 1'b1;
            pos_d      = pos_q + POS_ONE;
            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : (lock_cnt_q + LC_ONE);
          end
          DN: begin
            step_dn_d  = 1'b1;
            dir_d      = 1'b0;
            pos_d      = pos_q - POS_ONE;
            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : (lock_cnt_q + LC_ONE);
          end
          HOLD: begin
            lock_cnt_d = lock_cnt_q;
          end
          ILLEGAL: begin
            err_d      = 1'b1;
            lock_cnt_d = LC_ZERO;
            state_d    = ERROR;
          end
          default: begin
            err_d      = 1'b1;
            lock_cnt_d = LC_ZERO;
            state_d    = ERROR;
          end
        endcase
      end

      ERROR: begin
        lock_cnt_d = LC_ZERO;
`ifdef CNT5_DEC_STICKY_ERR_EN
        err_d   = 1'b1;
        state_d = ERROR;
`else
        state_d = ACQUIRE;
`endif
      end

      default: begin
        lock_cnt_d = LC_ZERO;
        state_d    = ACQUIRE;
      end
    endcase

    locked_d = (lock_cnt_d == LOCK_MAX);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACQUIRE;
      prev_q     <= '0;
      lock_cnt_q <= LC_ZERO;
      step_up_q  <= 1'b0;
      step_dn_q  <= 1'b0;
      dir_q      <= 1'b1;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      lock_cnt_q <= lock_cnt_d;
      step_up_q  <= step_up_d;
      step_dn_q  <= step_dn_d;
      dir_q      <= dir_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      pos_q      <= pos_d;
    end
  end

  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign dir     = dir_q;
  assign locked  = locked_q;
  assign err     = err_q;
  assign pos     = $signed(pos_q);

endmodule

// File: tb/tb_cnt5_dir_decoder.sv
module tb_cnt5_dir_decoder;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        cnt_in;
  logic              step_up;
  logic              step_dn;
  logic              dir;
  logic              locked;
  logic              err;
  logic signed [7:0] pos;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cnt5_dir_decoder dut (
    .clk     (clk),
    .reset   (reset),
    .cnt_in  (cnt_in),
    .step_up (step_up),
    .step_dn (step_dn),
    .dir     (dir),
    .locked  (locked),
    .err     (err),
    .pos     (pos)
  );

  // Observation vector: {step_up, step_dn, dir, locked, err, pos[7:0]}
  function automatic logic [12:0] obs_f();
    return {step_up, step_dn, dir, locked, err, pos};
  endfunction

  function automatic logic [12:0] ex(input logic u, input logic d, input logic di,
                                     input logic lk, input logic er, input logic [7:0] p);
    return {u, d, di, lk, er, p};
  endfunction

  // Present one sample, let the clock take it, then settle away from the edge.
  task automatic drive(input logic r, input logic [2:0] v);
    reset  = r;
    cnt_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] o;
    drive(1'b1, 3'd4);
    drive(1'b1, 3'd4);
    o = obs_f();
    checks++;
    if (o !== ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00)) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", o, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
    end
    // Out-of-range code while acquiring flags err without leaving ACQUIRE.
    drive(1'b0, 3'd7);
    o = obs_f();
    checks++;
    if (o !== ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00)) begin
      errors++;
      $display("FAIL acquire_oor: got %b expected %b", o, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00));
    end
    drive(1'b0, 3'd2);
    o = obs_f();
    checks++;
    if (o !== ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00)) begin
      errors++;
      $display("FAIL acquire_ok: got %b expected %b", o, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
    end
  endtask

  task automatic test_up();
    logic [2:0]  seq [7];
    logic [12:0] exp [7];
    logic [12:0] o;
    seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    exp[0] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    exp[1] = ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[2] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    exp[3] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
    exp[4] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4);
    exp[5] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5);
    exp[6] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd6);
    drive(1'b1, 3'd0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, seq[i]);
      o = obs_f();
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL up_seq[%0d]: got %b expected %b", i, o, exp[i]);
      end
    end
  endtask

  task automatic test_down();
    logic [2:0]  seq [7];
    logic [12:0] exp [7];
    logic [12:0] o;
    seq = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3};
    exp[0] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp[1] = ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    exp[2] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02);
    exp[3] = ex(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01);
    exp[4] = ex(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    exp[5] = ex(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    exp[6] = ex(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFE);
    drive(1'b1, 3'd0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, seq[i]);
      o = obs_f();
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL down_seq[%0d]: got %b expected %b", i, o, exp[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [2:0]  seq [6];
    logic [12:0] exp [6];
    logic [12:0] o;
    seq = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
    exp[0] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    exp[1] = ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[2] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    exp[3] = ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    exp[4] = ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    exp[5] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
    drive(1'b1, 3'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, seq[i]);
      o = obs_f();
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL hold_seq[%0d]: got %b expected %b", i, o, exp[i]);
      end
    end
  endtask

  task automatic test_error_jump();
    logic [2:0]  seq [6];
    logic [12:0] exp [6];
    logic [12:0] o;
    seq = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd4, 3'd0};
    exp[0] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    exp[1] = ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[2] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
`ifdef CNT5_DEC_STICKY_ERR_EN
    exp[3] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
    exp[4] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
    exp[5] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
`else
    exp[3] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[4] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[5] = ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
`endif
    drive(1'b1, 3'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, seq[i]);
      o = obs_f();
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL err_jump[%0d]: got %b expected %b", i, o, exp[i]);
      end
    end
    // Reset always clears the error condition.
    drive(1'b1, 3'd0);
    o = obs_f();
    checks++;
    if (o !== ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0)) begin
      errors++;
      $display("FAIL err_reset: got %b expected %b", o, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    end
  endtask

  task automatic test_error_range();
    logic [2:0]  seq [7];
    logic [12:0] exp [7];
    logic [12:0] o;
    seq = '{3'd0, 3'd1, 3'd6, 3'd2, 3'd6, 3'd2, 3'd3};
    exp[0] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    exp[1] = ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[2] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
`ifdef CNT5_DEC_STICKY_ERR_EN
    for (int i = 3; i < 7; i++) exp[i] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
`else
    exp[3] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[4] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
    exp[5] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[6] = ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
`endif
    drive(1'b1, 3'd0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, seq[i]);
      o = obs_f();
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL err_range[%0d]: got %b expected %b", i, o, exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [12:0] o;
    drive(1'b1, 3'd0);
    drive(1'b0, 3'd0);
    for (int k = 1; k <= 127; k++) drive(1'b0, 3'(k % 5));
    o = obs_f();
    checks++;
    if (o !== ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h7F)) begin
      errors++;
      $display("FAIL wrap_at_127: got %b expected %b", o, ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h7F));
    end
    drive(1'b0, 3'd2);
    o = obs_f();
    checks++;
    if (o !== ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h7F)) begin
      errors++;
      $display("FAIL wrap_hold: got %b expected %b", o, ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h7F));
    end
    drive(1'b0, 3'd3);
    checks++;
    if (pos !== -8'sd128 || step_up !== 1'b1) begin
      errors++;
      $display("FAIL wrap_overflow: got pos=%0d step_up=%b expected pos=-128 step_up=1", pos, step_up);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0]  seq [7];
    logic        rst [7];
    logic [12:0] exp [7];
    logic [12:0] o;
    seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    rst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp[0] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    exp[1] = ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[2] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    exp[3] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    exp[4] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    exp[5] = ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[6] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    drive(1'b1, 3'd0);
    for (int i = 0; i < 7; i++) begin
      drive(rst[i], seq[i]);
      o = obs_f();
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %b expected %b", i, o, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  seq [6];
    logic [12:0] exp [6];
    logic [12:0] o;
    seq = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1};
    exp[0] = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    exp[1] = ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    exp[2] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    exp[3] = ex(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    exp[4] = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    exp[5] = ex(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    drive(1'b1, 3'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, seq[i]);
      o = obs_f();
      checks++;
      if (o !== exp[i]) begin
        errors++;
        $display("FAIL reversal[%0d]: got %b expected %b", i, o, exp[i]);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    cnt_in = 3'd0;
    test_reset();
    test_up();
    test_down();
    test_hold();
    test_error_jump();
    test_error_range();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
